// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter between NREQ
// packet producers. One requester owns the transmitter per packet, or per
// MAX_BURST bytes when a burst limit is set.
module uart_tx_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 0,
    parameter int CW        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StKick, StBusy, StDrain} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic [7:0]      sel_data;
    logic            sel_valid, sel_last;
    logic [IW-1:0]   next_ptr;
    logic [NREQ-1:0] arb_grant;
    logic            arb_found;
    logic            accept;
    logic            burst_done;

    // Route the granted requester's byte and compute the pointer past it.
    always_comb begin
        sel_data = '0;
        next_ptr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                sel_data = sel_data | req_data[8*i +: 8];
                next_ptr = IW'((i + 1) % NREQ);
            end
        end
        sel_valid = |(grant_q & req_valid);
        sel_last  = |(grant_q & req_last);
    end

    // Round-robin pick: first valid requester at or above the pointer, wrapping.
    always_comb begin
        arb_grant = '0;
        arb_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!arb_found && req_valid[i] && ((int'(ptr_q) + k) % NREQ == i)) begin
                    arb_grant[i] = 1'b1;
                    arb_found    = 1'b1;
                end
            end
        end
    end

    // Handshake: only the owner, only in LOAD, only while the transmitter is idle.
    always_comb begin
        accept     = (state_q == StLoad) && tx_ready && sel_valid;
        req_ready  = accept ? grant_q : '0;
        burst_done = (MAX_BURST != 0) && (cnt_q == CW'(MAX_BURST));
    end

    // Next-state and datapath updates for the grant/transfer sequence.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    grant_d = arb_grant;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    tx_data_d  = sel_data;
                    last_d     = sel_last;
                    cnt_d      = cnt_q + CW'(1);
                    tx_start_d = 1'b1;  // registered, so high exactly during KICK
                    state_d    = StKick;
                end
            end
            StKick: state_d = StBusy;
            StBusy: begin
                // Transmitter has taken the byte once ready drops.
                if (!tx_ready) state_d = StDrain;
            end
            StDrain: begin
                if (tx_ready) begin
                    if (last_q || burst_done) begin
                        grant_d = '0;
                        cnt_d   = '0;
                        ptr_d   = next_ptr;
                        state_d = StIdle;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q != StIdle);
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed the inputs, a
// transmitter model answers tx_start, and a scoreboard holds the expected
// byte/owner order.
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] gnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_ready;

    exp_t       sb[$];
    logic [8:0] src0[$];
    logic [8:0] src1[$];
    logic [1:0] hs_q = '0;

    int passed    = 0;
    int total     = 0;
    int starts    = 0;
    int tx_low    = 2;
    int busy_cnt  = 0;
    int stall_cyc = 0;
    int abort_req = 0;
    bit stall_req = 1'b0;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(3), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .busy      (busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) hs_q <= req_valid & req_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input int r, input logic [7:0] d, input bit last);
        if (r == 0) src0.push_back({last, d});
        else        src1.push_back({last, d});
    endtask

    task automatic expect_byte(input int r, input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.gnt  = (r == 0) ? 2'b01 : 2'b10;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            done = (sb.size() == 0) && (src0.size() == 0) && (src1.size() == 0) &&
                   (busy === 1'b0) && (tx_ready === 1'b1);
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_grant_idle"}, grant, 0);
    endtask

    // Requester model: pop accepted bytes, present the queue heads.
    initial begin
        bit stall_used = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            if (hs_q[0] && src0.size() > 0) begin
                void'(src0.pop_front());
                if (stall_req && !stall_used) begin
                    stall_cyc  = 21;
                    stall_used = 1'b1;
                end
            end
            if (hs_q[1] && src1.size() > 0) void'(src1.pop_front());
            if (stall_cyc > 0) stall_cyc--;
            req_valid[0]  = (src0.size() > 0) && (stall_cyc == 0);
            req_data[7:0] = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
            req_last[0]   = (src0.size() > 0) ? src0[0][8] : 1'b0;
            req_valid[1]  = (src1.size() > 0);
            req_data[15:8] = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
            req_last[1]   = (src1.size() > 0) ? src1[0][8] : 1'b0;
        end
    end

    // Transmitter model and scoreboard check on every start pulse.
    initial begin
        exp_t e;
        int   abort_seen = 0;
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (abort_seen != abort_req) begin
                abort_seen = abort_req;
                busy_cnt   = 0;
                tx_ready   = 1'b1;
            end
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_ready = 1'b1;
            end
            if (tx_start === 1'b1) begin
                starts++;
                check("ready_at_start", 32'(tx_ready), 1);
                check("start_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("tx_data", tx_data, e.data);
                    check("grant_at_start", grant, e.gnt);
                end
                tx_ready = 1'b0;
                busy_cnt = tx_low;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s0;
        bit  found;
        rst = 1'b1;

        // Single requester 1, two-byte packet, with first-byte latency.
        do_reset();
        send(1, 8'h55, 1'b0);
        send(1, 8'hAA, 1'b1);
        expect_byte(1, 8'h55);
        expect_byte(1, 8'hAA);
        @(posedge clk);
        #1;
        check("t1_grant", grant, 2'b10);
        check("t1_busy", busy, 1);
        @(negedge clk);
        #1;
        check("t1_req_ready", req_ready, 2'b10);
        @(posedge clk);
        #1;
        check("t1_tx_start", tx_start, 1);
        check("t1_tx_data", tx_data, 8'h55);
        wait_done("t1", 200);

        // Contention: three 2-byte packets each, strict alternation from 0.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            send(0, 8'(8'h10 + 2 * p), 1'b0);
            send(0, 8'(8'h11 + 2 * p), 1'b1);
            send(1, 8'(8'h20 + 2 * p), 1'b0);
            send(1, 8'(8'h21 + 2 * p), 1'b1);
            expect_byte(0, 8'(8'h10 + 2 * p));
            expect_byte(0, 8'(8'h11 + 2 * p));
            expect_byte(1, 8'(8'h20 + 2 * p));
            expect_byte(1, 8'(8'h21 + 2 * p));
        end
        wait_done("t2", 600);

        // Owner stalls mid-packet; requester 1 must wait.
        do_reset();
        stall_req = 1'b1;
        send(0, 8'h30, 1'b0);
        send(0, 8'h31, 1'b1);
        send(1, 8'h40, 1'b1);
        expect_byte(0, 8'h30);
        expect_byte(0, 8'h31);
        expect_byte(1, 8'h40);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            found = (stall_cyc > 0);
        end
        check("t3_stall_seen", 32'(found), 1);
        s0 = starts;
        repeat (10) @(posedge clk);
        #1;
        check("t3_grant_held", grant, 2'b01);
        check("t3_req_ready", req_ready, 0);
        check("t3_no_start", 32'(starts - s0), 0);
        wait_done("t3", 300);

        // Burst limit of 3 splits requester 0's 5-byte packet around requester 1.
        do_reset();
        for (int b = 0; b < 5; b++) send(0, 8'(8'h50 + b), b == 4);
        send(1, 8'h60, 1'b0);
        send(1, 8'h61, 1'b1);
        expect_byte(0, 8'h50);
        expect_byte(0, 8'h51);
        expect_byte(0, 8'h52);
        expect_byte(1, 8'h60);
        expect_byte(1, 8'h61);
        expect_byte(0, 8'h53);
        expect_byte(0, 8'h54);
        wait_done("t4", 600);

        // Slow transmitter: one start per byte.
        tx_low = 1000;
        s0 = starts;
        send(0, 8'h70, 1'b0);
        send(0, 8'h71, 1'b0);
        send(0, 8'h72, 1'b1);
        expect_byte(0, 8'h70);
        expect_byte(0, 8'h71);
        expect_byte(0, 8'h72);
        wait_done("t5", 4000);
        check("t5_start_count", 32'(starts - s0), 3);
        tx_low = 2;

        // Reset in BUSY; pointer must return to requester 0.
        do_reset();
        send(0, 8'h80, 1'b1);
        expect_byte(0, 8'h80);
        wait_done("t6a", 200);
        tx_low = 1000;
        send(1, 8'h90, 1'b0);
        send(1, 8'h91, 1'b1);
        expect_byte(1, 8'h90);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            found = (tx_start === 1'b1);
        end
        check("t6_start_seen", 32'(found), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        src0.delete();
        src1.delete();
        sb.delete();
        abort_req++;
        tx_low = 2;
        @(posedge clk);
        #1;
        check("t6_grant", grant, 0);
        check("t6_tx_start", tx_start, 0);
        check("t6_busy", busy, 0);
        check("t6_tx_data", tx_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(0, 8'hA0, 1'b1);
        send(1, 8'hB0, 1'b1);
        expect_byte(0, 8'hA0);
        expect_byte(1, 8'hB0);
        wait_done("t6b", 300);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
